// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 32-bit instructions as four little-endian byte reads and hands them to decode.
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   mem_req/mem_addr    byte read request and its address (pc + byte index)
//   mem_rdata/mem_ack   read data and same-cycle acknowledge (low = wait state)
//   inst_valid/ready    handshake for the assembled word towards decode
//   inst_code/inst_pc   assembled word {b3,b2,b1,b0} and its address
//   redirect_valid/pc   load a new word-aligned PC and drop the fetch in flight
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, code_q, code_d, ipc_q, ipc_d;
    logic [1:0]  k_q, k_d;
    logic [23:0] lane_q, lane_d;
    assign mem_req    = state_q == FETCH;
    assign inst_valid = state_q == HOLD;
    assign mem_addr   = pc_q + {30'd0, k_q};
    assign inst_code  = code_q;
    assign inst_pc    = ipc_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        k_d     = k_q;
        lane_d  = lane_q;
        code_d  = code_q;
        ipc_d   = ipc_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: if (mem_ack) begin
                lane_d = {k_q == 2'd2 ? mem_rdata : lane_q[23:16],
                          k_q == 2'd1 ? mem_rdata : lane_q[15:8],
                          k_q == 2'd0 ? mem_rdata : lane_q[7:0]};
                // k wraps 3 -> 0 naturally as the word completes
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    code_d  = {mem_rdata, lane_q};
                    ipc_d   = pc_q;
                    state_d = HOLD;
                end
            end
            HOLD: if (inst_ready) begin
                pc_d    = pc_q + 32'd4;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        // redirect overrides everything above, including a completing byte or an accepted word
        if (redirect_valid && state_q != IDLE) begin
            pc_d    = redirect_pc & ~32'd3;
            k_d     = 2'd0;
            state_d = FETCH;
            code_d  = code_q;
            ipc_d   = ipc_q;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            k_q     <= 2'd0;
            lane_q  <= 24'd0;
            code_q  <= 32'd0;
            ipc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            k_q     <= k_d;
            lane_q  <= lane_d;
            code_q  <= code_d;
            ipc_q   <= ipc_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a word-level model.
module tb_fetch_sequencer;
    logic        clock = 1'b0, reset = 1'b1;
    logic        mem_req, mem_ack, inst_valid, inst_ready, redirect_valid;
    logic [31:0] mem_addr, inst_code, inst_pc, redirect_pc;
    logic [7:0]  mem_rdata;
    logic        w_req, w_ack, w_valid;
    logic [31:0] w_addr, w_code, w_pc;
    logic [7:0]  w_rdata;
    int          checks = 0, errors = 0;
    bit          started, holding;
    int          n;
    logic [31:0] mpc, lcode, lpc;

    always #5 clock = ~clock;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd29) ^ a[23:16] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    assign mem_rdata = byte_at(mem_addr);
    assign w_rdata   = byte_at(w_addr);
    assign w_ack     = w_req;

    fetch_sequencer u_dut (
        .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_code(inst_code), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clock(clock), .reset(reset), .mem_req(w_req), .mem_addr(w_addr),
        .mem_rdata(w_rdata), .mem_ack(w_ack), .inst_valid(w_valid),
        .inst_ready(1'b1), .inst_code(w_code), .inst_pc(w_pc),
        .redirect_valid(1'b0), .redirect_pc(32'd0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        started = 0;
        holding = 0;
        n       = 0;
        mpc     = 32'd0;
        lcode   = 32'd0;
        lpc     = 32'd0;
    endtask

    task automatic check_all();
        chk("req", {31'd0, mem_req}, {31'd0, started && !holding});
        chk("valid", {31'd0, inst_valid}, {31'd0, holding});
        if (!holding) chk("addr", mem_addr, mpc + 32'(n));
        chk("code", inst_code, lcode);
        chk("ipc", inst_pc, lpc);
    endtask

    // One clock: drive inputs, advance the word-level model across the edge, check after it.
    task automatic step(input bit a, input bit r, input bit v, input logic [31:0] p);
        mem_ack        = a;
        inst_ready     = r;
        redirect_valid = v;
        redirect_pc    = p;
        if (!started) started = 1;
        else if (v) begin
            mpc     = {p[31:2], 2'b00};
            n       = 0;
            holding = 0;
        end else if (holding) begin
            if (r) begin
                mpc     = mpc + 32'd4;
                holding = 0;
            end
        end else if (a) begin
            if (n == 3) begin
                n       = 0;
                holding = 1;
                lcode   = word_at(mpc);
                lpc     = mpc;
            end else n++;
        end
        @(negedge clock);
        check_all();
    endtask

    initial begin
        mem_ack = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
        reset_model();
        repeat (2) @(negedge clock);
        check_all();
        chk("w_rst_req", {31'd0, w_req}, 32'd0);
        chk("w_rst_addr", w_addr, 32'hFFFF_FFFC);
        chk("w_rst_pc", w_pc, 32'hFFFF_FFFC);
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0);
            if (i < 4) begin
                chk("w_req", {31'd0, w_req}, 32'd1);
                chk("w_addr", w_addr, 32'hFFFF_FFFC + 32'(i));
            end else if (i == 4) begin
                chk("first_valid", {31'd0, inst_valid}, 32'd1);
                chk("first_code", inst_code, 32'h0010_0513);
                chk("first_pc", inst_pc, 32'd0);
                chk("w_valid", {31'd0, w_valid}, 32'd1);
                chk("w_code", w_code, word_at(32'hFFFF_FFFC));
                chk("w_pc", w_pc, 32'hFFFF_FFFC);
            end else begin
                chk("next_addr", mem_addr, 32'd4);
                chk("w_wrap_addr", w_addr, 32'd0);
                chk("w_wrap_req", {31'd0, w_req}, 32'd1);
            end
        end
        repeat (4) step(1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        chk("bp_req", {31'd0, mem_req}, 32'd0);
        step(1, 1, 0, 0);
        chk("bp_next_addr", mem_addr, 32'd8);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wait_addr", mem_addr, 32'd10);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("wait_word", inst_code, word_at(32'd8));
        step(0, 1, 1, 32'h0000_0200);
        chk("redir_hold_valid", {31'd0, inst_valid}, 32'd0);
        chk("redir_hold_addr", mem_addr, 32'h0000_0200);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0103);
        chk("redir_addr", mem_addr, 32'h0000_0100);
        for (int i = 0; i < 20 && !inst_valid; i++) step(1, 0, 0, 0);
        chk("redir_valid", {31'd0, inst_valid}, 32'd1);
        chk("redir_pc", inst_pc, 32'h0000_0100);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom);
        step(0, 1, 1, 32'h0000_0040);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        @(posedge clock);
        #2 reset = 1;
        #1;
        chk("async_req", {31'd0, mem_req}, 32'd0);
        chk("async_valid", {31'd0, inst_valid}, 32'd0);
        chk("async_addr", mem_addr, 32'd0);
        chk("async_code", inst_code, 32'd0);
        chk("async_pc", inst_pc, 32'd0);
        chk("async_w_req", {31'd0, w_req}, 32'd0);
        chk("async_w_addr", w_addr, 32'hFFFF_FFFC);
        @(negedge clock);
        reset_model();
        check_all();
        reset = 0;
        repeat (12) step(1, 1, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
